demap_modulations: RTL



---
 rtl/demap_modulations.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/demap_modulations.sv
// Hard-decision OFDM demapper: slices 8 I/Q symbols per beat, Gray-decodes each axis and packs
// the recovered bits LSB-first into 64-bit words through a three-stage pipeline.
module demap_modulations #(
  parameter int    DATA_SIZE  = 16,
  parameter string MODULATION = "BPSK"
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [8*DATA_SIZE-1:0] in_i,
  input  logic [8*DATA_SIZE-1:0] in_q,
  output logic                   out_valid,
  output logic [63:0]            out_data,
  output logic [6:0]             out_nbits,
  output logic                   out_last
);

  localparam int Bps = (MODULATION == "BPSK")   ? 1 :
                       (MODULATION == "QPSK")   ? 2 :
                       (MODULATION == "QAM16")  ? 4 :
                       (MODULATION == "QAM64")  ? 6 :
                       (MODULATION == "QAM256") ? 8 : 0;
  localparam int Levels    = (Bps <= 2) ? 2 : (1 << (Bps / 2));
  localparam int ChunkBits = 8 * Bps;
  localparam int AxisBits  = (Bps == 1) ? 1 : Bps / 2;
  localparam int SW        = DATA_SIZE + 2;

  localparam logic signed [SW-1:0] LevelsS = SW'(Levels);
  localparam logic signed [SW-1:0] KMaxS   = SW'(Levels - 1);
  localparam logic [3:0]           KMax    = 4'(Levels - 1);
  localparam logic [7:0]           IMask   = 8'((1 << AxisBits) - 1);
  localparam logic [7:0]           QMask   = (Bps == 1) ? 8'd0 : IMask;

  // QAM256 axis code indexed by level index (0 = most negative level).
  localparam logic [15:0][3:0] Gray256 = {4'h9, 4'hD, 4'hF, 4'hB, 4'hA, 4'hE, 4'hC, 4'h8,
                                          4'h0, 4'h4, 4'h6, 4'h2, 4'h3, 4'h7, 4'h5, 4'h1};

  if (Bps == 0) begin : gen_bad_modulation
    $error("demap_modulations: unsupported MODULATION %s", MODULATION);
  end

  // Nearest level index: floor((x+L)/2) clamped to [0, L-1]; even x rounds upward.
  function automatic logic [3:0] slice_axis(input logic signed [DATA_SIZE-1:0] x);
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] k;
    sum = {{2{x[DATA_SIZE-1]}}, x} + LevelsS;
    k   = sum >>> 1;
    if (k[SW-1]) return 4'd0;
    if (k > KMaxS) return KMax;
    return k[3:0];
  endfunction

  // BPSK..QAM64 use the reflected binary code; QAM256 has its own table.
  function automatic logic [3:0] gray_decode(input logic [3:0] k);
    logic [3:0] g;
    g = k ^ {1'b0, k[3:1]};
    if (Bps == 8) g = Gray256[k];
    return g;
  endfunction

  logic accept;
  logic block_q, block_d;

  logic            s1_valid_q, s1_last_q;
  logic [7:0][3:0] s1_ki_q, s1_kq_q, s1_ki_d, s1_kq_d;

  logic        s2_valid_q, s2_last_q;
  logic [63:0] s2_chunk_q, chunk_d;

  logic [127:0] gbuf_q, gbuf_d, merged;
  logic [6:0]   fill_q, fill_d;
  logic [7:0]   total;
  logic         pend_q, pend_d;

  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;
  logic [6:0]  out_nbits_q, out_nbits_d;
  logic        out_last_q, out_last_d;

  logic [3:0] gi, gq;
  logic [7:0] sym;

  assign in_ready = ~rst & ~block_q;
  assign accept   = in_valid & in_ready;
  assign block_d  = accept & in_last;

  // Outputs read zero for the whole reset cycle, not only after the clearing edge.
  assign out_valid = out_valid_q & ~rst;
  assign out_data  = rst ? 64'd0 : out_data_q;
  assign out_nbits = rst ? 7'd0 : out_nbits_q;
  assign out_last  = out_last_q & ~rst;

  always_comb begin
    s1_ki_d = '0;
    s1_kq_d = '0;
    for (int s = 0; s < 8; s++) begin
      s1_ki_d[s] = slice_axis(in_i[DATA_SIZE*s +: DATA_SIZE]);
      s1_kq_d[s] = slice_axis(in_q[DATA_SIZE*s +: DATA_SIZE]);
    end
  end

  always_comb begin
    chunk_d = '0;
    gi      = '0;
    gq      = '0;
    sym     = '0;
    for (int s = 0; s < 8; s++) begin
      gi      = gray_decode(s1_ki_q[s]);
      gq      = gray_decode(s1_kq_q[s]);
      sym     = ({4'd0, gi} & IMask) | (({4'd0, gq} & QMask) << AxisBits);
      chunk_d = chunk_d | ({56'd0, sym} << (s * Bps));
    end
  end

  always_comb begin
    merged      = gbuf_q | ({64'd0, s2_chunk_q} << fill_q);
    total       = {1'b0, fill_q} + 8'(ChunkBits);
    gbuf_d      = gbuf_q;
    fill_d      = fill_q;
    pend_d      = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_nbits_d = out_nbits_q;
    out_last_d  = out_last_q;
    if (pend_q) begin
      // Tail of a frame that overflowed one word on its last chunk.
      out_valid_d = 1'b1;
      out_data_d  = gbuf_q[63:0];
      out_nbits_d = fill_q;
      out_last_d  = 1'b1;
      gbuf_d      = '0;
      fill_d      = '0;
    end else if (s2_valid_q) begin
      if (s2_last_q && total <= 8'd64) begin
        out_valid_d = 1'b1;
        out_data_d  = merged[63:0];
        out_nbits_d = total[6:0];
        out_last_d  = 1'b1;
        gbuf_d      = '0;
        fill_d      = '0;
      end else if (total >= 8'd64) begin
        out_valid_d = 1'b1;
        out_data_d  = merged[63:0];
        out_nbits_d = 7'd64;
        out_last_d  = 1'b0;
        gbuf_d      = merged >> 64;
        fill_d      = 7'(total - 8'd64);
        pend_d      = s2_last_q;
      end else begin
        gbuf_d = merged;
        fill_d = total[6:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      block_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      gbuf_q      <= '0;
      fill_q      <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_nbits_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      block_q     <= block_d;
      s1_valid_q  <= accept;
      s2_valid_q  <= s1_valid_q;
      gbuf_q      <= gbuf_d;
      fill_q      <= fill_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_nbits_q <= out_nbits_d;
      out_last_q  <= out_last_d;
    end
  end

  // Datapath registers are qualified by the valids above and need no reset.
  always_ff @(posedge clk) begin
    s1_ki_q    <= s1_ki_d;
    s1_kq_q    <= s1_kq_d;
    s1_last_q  <= in_last;
    s2_chunk_q <= chunk_d;
    s2_last_q  <= s1_last_q;
  end

endmodule
